// File: rtl/trace_axis_packetizer.sv
// Trace packetizer: event counters, write-strobe edge detector and an
// AXI4-Stream master fed from a small first-word-fall-through queue.
module trace_axis_packetizer #(
  parameter int PAYLOAD_WIDTH = 160,
  parameter int NUM_EVENTS    = 115,
  parameter int CNT_WIDTH     = 7,
  parameter int FIFO_DEPTH    = 4,
  localparam int TDATA_WIDTH  = PAYLOAD_WIDTH + NUM_EVENTS * CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sig,
  output logic                     pos_edge,
  output logic                     neg_edge,
  input  logic                     write_enable,
  input  logic [PAYLOAD_WIDTH-1:0] payload,
  input  logic [NUM_EVENTS-1:0]    performance_events,
  input  logic                     tlast_request,
  input  logic [31:0]              tlast_interval,
  output logic                     M_AXIS_tvalid,
  input  logic                     M_AXIS_tready,
  output logic [TDATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic                     M_AXIS_tlast,
  output logic                     overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic                   sig_q;
  logic [CNT_WIDTH-1:0]   cnt [NUM_EVENTS];
  logic [TDATA_WIDTH-1:0] snap;
  logic [TDATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [AW:0]            count;
  logic [31:0]            frame;
  logic                   full;
  logic                   pop;
  logic                   accept;
  logic                   last_new;

  assign pos_edge = rst_n & sig & ~sig_q;
  assign neg_edge = rst_n & ~sig & sig_q;

  assign full          = count == (AW+1)'(FIFO_DEPTH);
  assign M_AXIS_tvalid = count != '0;
  assign pop           = M_AXIS_tvalid & M_AXIS_tready;
  assign accept        = write_enable & (~full | pop);

  assign last_new = tlast_request |
    (tlast_interval != 32'd0 &&
     ({1'b0, frame} + 33'd1) >= {1'b0, tlast_interval});

  // Stale RAM contents never leak: outputs read zero while empty.
  assign M_AXIS_tdata = M_AXIS_tvalid ?
    mem[rd_ptr][TDATA_WIDTH-1:0] : '0;
  assign M_AXIS_tlast = M_AXIS_tvalid & mem[rd_ptr][TDATA_WIDTH];

  always_comb begin
    snap = '0;
    snap[TDATA_WIDTH-1 -: PAYLOAD_WIDTH] = payload;
    for (int i = 0; i < NUM_EVENTS; i++)
      snap[(NUM_EVENTS-1-i)*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end

  // Snapshot restarts from this cycle's events so none are lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_EVENTS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++)
        cnt[i] <= write_enable ?
          CNT_WIDTH'(performance_events[i]) :
          cnt[i] + CNT_WIDTH'(performance_events[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      frame    <= '0;
      overflow <= 1'b0;
    end else begin
      sig_q <= sig;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        frame  <= last_new ? 32'd0 : frame + 32'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (write_enable && !accept)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= {last_new, snap};
  end

endmodule

// File: tb/tb_trace_axis_packetizer.sv
// Directed bench for trace_axis_packetizer: edges, counters,
// framing, backpressure, full-with-pop and mid-stream reset.
module tb_trace_axis_packetizer;

  localparam int PW = 160;
  localparam int NE = 115;
  localparam int CW = 7;
  localparam int TW = PW + NE * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sig;
  logic          pos_edge;
  logic          neg_edge;
  logic          write_enable;
  logic [PW-1:0] payload;
  logic [NE-1:0] ev;
  logic          tlast_request;
  logic [31:0]   tlast_interval;
  logic          tvalid;
  logic          tready;
  logic [TW-1:0] tdata;
  logic          tlast;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  trace_axis_packetizer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sig                (sig),
    .pos_edge           (pos_edge),
    .neg_edge           (neg_edge),
    .write_enable       (write_enable),
    .payload            (payload),
    .performance_events (ev),
    .tlast_request      (tlast_request),
    .tlast_interval     (tlast_interval),
    .M_AXIS_tvalid      (tvalid),
    .M_AXIS_tready      (tready),
    .M_AXIS_tdata       (tdata),
    .M_AXIS_tlast       (tlast),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [159:0] got,
                       logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pl();
    return tdata[TW-1 -: PW];
  endfunction

  function automatic logic [CW-1:0] cf(int i);
    return tdata[(NE-1-i)*CW +: CW];
  endfunction

  task automatic wr(logic [PW-1:0] p, logic req);
    write_enable  = 1'b1;
    payload       = p;
    tlast_request = req;
    tick();
    write_enable  = 1'b0;
    tlast_request = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic       sv [6]  = '{0, 1, 1, 1, 0, 0};
  logic       pe [6]  = '{0, 1, 0, 0, 0, 0};
  logic       ne [6]  = '{0, 0, 0, 0, 1, 0};
  logic       rq [13] = '{0,0,0,0,0,0,1,0,0,0,0,1,0};
  logic       tl [13] = '{0,0,1,0,0,1,1,0,0,1,0,1,0};

  initial begin
    rst_n = 1'b0;
    sig = 1'b0;
    write_enable = 1'b0;
    payload = '0;
    ev = '0;
    tlast_request = 1'b0;
    tlast_interval = 32'd0;
    tready = 1'b0;
    tick();
    tick();
    sig = 1'b1;
    #1;
    check("rst_pos", pos_edge, 0);
    check("rst_neg", neg_edge, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", pl(), 0);
    check("rst_ovf", overflow, 0);
    sig = 1'b0;
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      sig = sv[i];
      #1;
      check($sformatf("pos%0d", i), pos_edge, pe[i]);
      check($sformatf("neg%0d", i), neg_edge, ne[i]);
      tick();
    end

    ev[0] = 1'b1;
    repeat (5) tick();
    check("empty_pre", tvalid, 0);
    wr(160'hABC, 1'b0);
    check("lat_tvalid", tvalid, 1);
    check("cnt0_5", cf(0), 5);
    check("cnt1_0", cf(1), 0);
    check("pl_abc", pl(), 160'hABC);
    check("tlast_off0", tlast, 0);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    tick();
    wr(160'h2, 1'b0);
    check("cnt0_3", cf(0), 3);
    check("pl_2", pl(), 2);
    tready = 1'b1;
    ev = '0;
    ev[NE-1] = 1'b1;
    tick();
    tready = 1'b0;
    repeat (129) tick();
    ev = '0;
    wr(160'h3, 1'b0);
    check("cnt114_wrap", cf(NE-1), 2);
    check("cnt0_hold", cf(0), 1);
    check("tlast_off1", tlast, 0);
    tready = 1'b1;
    tick();
    tready = 1'b0;

    do_reset();
    tready = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tlast_interval = (k <= 10) ? 32'd3 : 32'd0;
      wr(PW'(k), rq[k-1]);
      check($sformatf("frm_v%0d", k), tvalid, 1);
      check($sformatf("frm_p%0d", k), pl(), PW'(k));
      check($sformatf("frm_l%0d", k), tlast, tl[k-1]);
    end
    tick();
    check("frm_drain", tvalid, 0);

    tready = 1'b0;
    tlast_interval = 32'd0;
    for (int k = 1; k <= 6; k++) wr(PW'(k), 1'b0);
    check("bp_ovf", overflow, 1);
    tick();
    check("bp_hold", pl(), 1);
    tick();
    check("bp_hold2", pl(), 1);
    tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("bp_v%0d", k), tvalid, 1);
      check($sformatf("bp_p%0d", k), pl(), PW'(k));
      tick();
    end
    check("bp_empty", tvalid, 0);

    do_reset();
    tready = 1'b0;
    for (int k = 1; k <= 4; k++) wr(PW'(k), 1'b0);
    tready = 1'b1;
    wr(160'h9, 1'b0);
    check("fp_ovf", overflow, 0);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("fp_p%0d", k), pl(), (k == 5) ? 9 : k);
      tick();
    end
    check("fp_empty", tvalid, 0);

    tready = 1'b0;
    tlast_interval = 32'd2;
    ev[0] = 1'b1;
    for (int k = 1; k <= 3; k++) wr(PW'(k), 1'b0);
    check("mr_pre", tvalid, 1);
    rst_n = 1'b0;
    tick();
    check("mr_tvalid", tvalid, 0);
    check("mr_tdata", pl(), 0);
    check("mr_tlast", tlast, 0);
    rst_n = 1'b1;
    ev = '0;
    wr(160'h11, 1'b0);
    wr(160'h12, 1'b0);
    check("mr_cnt0", cf(0), 0);
    check("mr_p1", pl(), 160'h11);
    check("mr_l1", tlast, 0);
    tready = 1'b1;
    tick();
    check("mr_p2", pl(), 160'h12);
    check("mr_l2", tlast, 1);
    tick();
    check("mr_empty", tvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
